// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pkg
//  Description : Shared defaults, FSM state encoding and special-value
//                patterns for the posit decode path.
//  Revision    : 1.0 - initial release
// ============================================================================
package posit_pkg;

    // Default posit geometry consumed by posit_decoder and exp_adder
    localparam int POSIT_N      = 32;
    localparam int POSIT_ES     = 3;
    localparam int POSIT_K_BITS = 6;

    // Decoder control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_EXTRACT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Special encodings at the default width
    localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;
    localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/posit_regime_scan.sv
`default_nettype none
// ============================================================================
//  Module      : posit_regime_scan
//  Description : Serial regime-run scanner. Holds the posit body shift
//                register, the run counter and the leading regime bit; one
//                body bit is consumed per shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_regime_scan #(
    parameter int N  = 32,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          shift,
    input  logic [N-2:0]  load_value,
    output logic [N-2:0]  body,
    output logic [CW-1:0] cnt,
    output logic          r0,
    output logic          stop
);

    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    // Load the magnitude body, then shift out one regime bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            body <= '0;
            cnt  <= '0;
            r0   <= 1'b0;
        end else if (load) begin
            body <= load_value;
            cnt  <= '0;
            r0   <= load_value[N-2];
        end else if (shift) begin
            body <= {body[N-3:0], 1'b0};
            cnt  <= cnt + CW'(1);
        end
    end

    // Run ends at the terminator bit or when the whole body was regime
    always_comb begin
        stop = (body[N-2] != r0) || (cnt == CNT_MAX);
    end

endmodule
`default_nettype wire

// File: rtl/posit_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : posit_decoder
//  Description : Multi-cycle posit field extractor (sign, regime k, exponent,
//                MSB-aligned fraction, zero/NaR flags) feeding exp_adder.
//                Optional macro POSIT_DEC_EXPRAW_EN adds the combined scaled
//                exponent output exp_raw = (k << ES) + exp.
//  Revision    : 1.0 - initial release
// ============================================================================
module posit_decoder
    import posit_pkg::*;
#(
    parameter  int N         = POSIT_N,
    parameter  int ES        = POSIT_ES,
    parameter  int K_BITS    = POSIT_K_BITS,
    localparam int FRAC_BITS = N - ES - 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N-1:0]             posit_in,
    output logic                     sign,
    output logic signed [K_BITS-1:0] k,
    output logic [ES-1:0]            exp,
    output logic [FRAC_BITS-1:0]     frac,
    output logic                     NaR,
    output logic                     zero_out,
    output logic                     done
`ifdef POSIT_DEC_EXPRAW_EN
    ,
    output logic signed [ES+K_BITS:0] exp_raw
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [N-1:0]  NAR_PAT = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] M_MAX   = CW'(N - 1);

    state_t                   state, state_nxt;
    logic [N-2:0]             body;
    logic [CW-1:0]            cnt;
    logic                     r0, stop, load, shift;
    logic [N-1:0]             mag;
    logic                     in_zero, in_nar;
    logic [K_BITS-1:0]        m_ext;
    logic signed [K_BITS-1:0] k_val, k_nxt;
    logic [ES-1:0]            exp_val, exp_nxt;
    logic [FRAC_BITS-1:0]     frac_val, frac_nxt;
    logic                     sign_nxt, nar_nxt, zero_nxt, done_nxt;
    logic                     unused_bits;
`ifdef POSIT_DEC_EXPRAW_EN
    logic signed [ES+K_BITS:0] exp_raw_val, exp_raw_nxt;
`endif

    // Classify the operand and form its magnitude for the regime scan
    always_comb begin
        in_zero = (posit_in == '0);
        in_nar  = (posit_in == NAR_PAT);
        mag     = posit_in[N-1] ? -posit_in : posit_in;
        load    = (state == ST_IDLE) && start && !in_zero && !in_nar;
        shift   = (state == ST_SCAN) && !stop;
    end

    // The magnitude MSB is only nonzero for NaR, and body[0] is always fill
    assign unused_bits = ^{mag[N-1], body[0]};

    posit_regime_scan #(
        .N  (N),
        .CW (CW)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .shift      (shift),
        .load_value (mag[N-2:0]),
        .body       (body),
        .cnt        (cnt),
        .r0         (r0),
        .stop       (stop)
    );

    // Field extraction from the shifted body once the run length is known
    always_comb begin
        m_ext = {{(K_BITS-CW){1'b0}}, cnt};
        k_val = r0 ? (m_ext - K_BITS'(1)) : -m_ext;
        if (cnt == M_MAX) begin
            exp_val  = '0;
            frac_val = '0;
        end else begin
            // body[N-2] is the terminator; zero fill pads truncated fields
            exp_val  = body[N-3 -: ES];
            frac_val = body[N-3-ES:1];
        end
`ifdef POSIT_DEC_EXPRAW_EN
        exp_raw_val = ($signed({{(ES+1){k_val[K_BITS-1]}}, k_val}) <<< ES)
                    + $signed({{(K_BITS+1){1'b0}}, exp_val});
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE dwells until the done pulse has been issued
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (in_zero || in_nar) ? ST_DONE : ST_SCAN;
            ST_SCAN:    if (stop) state_nxt = ST_EXTRACT;
            ST_EXTRACT: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = done ? ST_IDLE : ST_DONE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Output next values: results hold except on accept and extract
    always_comb begin
        sign_nxt = sign;
        k_nxt    = k;
        exp_nxt  = exp;
        frac_nxt = frac;
        nar_nxt  = NaR;
        zero_nxt = zero_out;
        done_nxt = 1'b0;
`ifdef POSIT_DEC_EXPRAW_EN
        exp_raw_nxt = exp_raw;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    sign_nxt = posit_in[N-1];
                    k_nxt    = '0;
                    exp_nxt  = '0;
                    frac_nxt = '0;
                    nar_nxt  = in_nar;
                    zero_nxt = in_zero;
`ifdef POSIT_DEC_EXPRAW_EN
                    exp_raw_nxt = '0;
`endif
                end
            end
            ST_EXTRACT: begin
                k_nxt    = k_val;
                exp_nxt  = exp_val;
                frac_nxt = frac_val;
                done_nxt = 1'b1;
`ifdef POSIT_DEC_EXPRAW_EN
                exp_raw_nxt = exp_raw_val;
`endif
            end
            ST_DONE:  done_nxt = ~done;
            default:  done_nxt = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign     <= 1'b0;
            k        <= '0;
            exp      <= '0;
            frac     <= '0;
            NaR      <= 1'b0;
            zero_out <= 1'b0;
            done     <= 1'b0;
`ifdef POSIT_DEC_EXPRAW_EN
            exp_raw  <= '0;
`endif
        end else begin
            sign     <= sign_nxt;
            k        <= k_nxt;
            exp      <= exp_nxt;
            frac     <= frac_nxt;
            NaR      <= nar_nxt;
            zero_out <= zero_nxt;
            done     <= done_nxt;
`ifdef POSIT_DEC_EXPRAW_EN
            exp_raw  <= exp_raw_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
